// File: rtl/aes_mode_ctrl.sv
// ECB/CBC front-end for a combinational AES-128 core: gathers four 32-bit words,
// launches the block, waits CORE_LAT cycles for the core to settle, returns ciphertext.
module aes_mode_ctrl #(
  parameter int unsigned CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key,
  input  logic [127:0] core_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {S_COLLECT, S_WAIT, S_HOLD} state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(CORE_LAT - 1);

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [95:0]  buf_q, buf_d;
  logic [3:0]   settle_q, settle_d;
  logic         mode_q, mode_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] din_q, din_d;
  logic [127:0] key_q, key_d;
  logic [127:0] odata_q, odata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_COLLECT;
      cnt_q    <= '0;
      buf_q    <= '0;
      settle_q <= '0;
      mode_q   <= 1'b0;
      chain_q  <= '0;
      din_q    <= '0;
      key_q    <= '0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
      chain_q  <= chain_d;
      din_q    <= din_d;
      key_q    <= key_d;
      odata_q  <= odata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    chain_d  = chain_q;
    din_d    = din_q;
    key_d    = key_q;
    odata_d  = odata_q;
    in_ready = 1'b0;

    case (state_q)
      S_COLLECT: begin
        in_ready = 1'b1;
        // A new IV may only be installed before the first word of a block lands.
        if (iv_load && (cnt_q == 2'd0)) chain_d = iv;
        if (in_valid) begin
          if (cnt_q == 2'd3) begin
            din_d    = {buf_q, in_data} ^ (mode ? chain_q : 128'd0);
            key_d    = key;
            mode_d   = mode;
            cnt_d    = 2'd0;
            settle_d = SETTLE_INIT;
            state_d  = S_WAIT;
          end else begin
            buf_d = {buf_q[63:0], in_data};
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_WAIT: begin
        if (settle_q == 4'd0) begin
          odata_d = core_data_out;
          if (mode_q) chain_d = core_data_out;
          state_d = S_HOLD;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  assign out_valid    = (state_q == S_HOLD);
  assign out_data     = odata_q;
  assign core_data_in = din_q;
  assign core_key     = key_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl; the AES core is stood in for by a table of
// published FIPS-197 / SP800-38A block-cipher pairs.
module tb_aes_mode_ctrl;

  localparam int CORE_LAT = 2;

  localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] IN1    = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] CT1    = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] IN2    = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] CT2    = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CT_E1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] BOGUS  = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [127:0] key;
  logic         iv_load;
  logic [127:0] iv;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [127:0] core_data_in;
  logic [127:0] core_key;
  logic [127:0] core_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int words    = 0;
  int xfers    = 0;
  int launch_cyc = 0;
  int w0, x0;

  aes_mode_ctrl #(.CORE_LAT(CORE_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .key          (key),
    .iv_load      (iv_load),
    .iv           (iv),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .core_data_in (core_data_in),
    .core_key     (core_key),
    .core_data_out(core_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  // Reference cipher pairs; anything else yields an unrelated pattern.
  always_comb begin
    core_data_out = core_data_in ^ core_key ^ 128'h5a5a5a5a_a5a5a5a5_5a5a5a5a_a5a5a5a5;
    if (core_key == K1 && core_data_in == PT_C1) core_data_out = CT_C1;
    if (core_key == K2 && core_data_in == IN1)   core_data_out = CT1;
    if (core_key == K2 && core_data_in == IN2)   core_data_out = CT2;
    if (core_key == K2 && core_data_in == PT1)   core_data_out = CT_E1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready)   words <= words + 1;
    if (rst_n && out_valid && out_ready) xfers <= xfers + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},     in_ready,     1);
    check({tag, "_out_valid"},    out_valid,    0);
    check({tag, "_out_data"},     out_data,     0);
    check({tag, "_core_data_in"}, core_data_in, 0);
    check({tag, "_core_key"},     core_key,     0);
  endtask

  task automatic send_block(input logic [127:0] pt, input int nwords, input int iv_at,
                            input logic [127:0] ivv);
    int guard;
    for (int i = 0; i < nwords; i++) begin
      in_valid = 1'b1;
      in_data  = pt[127-32*i -: 32];
      iv_load  = (i == iv_at);
      iv       = ivv;
      guard    = 0;
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check("word_accept_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    iv_load    = 1'b0;
    launch_cyc = cyc;
  endtask

  task automatic expect_result(input string tag, input logic [127:0] exp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid"},   out_valid, 1);
    check({tag, "_latency"}, cyc - launch_cyc, CORE_LAT);
    check({tag, "_data"},    out_data, exp);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_pulse_end"}, out_valid, 0);
      check({tag, "_ready_back"}, in_ready, 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    key       = '0;
    iv_load   = 1'b0;
    iv        = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ECB, FIPS-197 C.1
    mode = 1'b0;
    key  = K1;
    send_block(PT_C1, 4, -1, '0);
    check("ecb_c1_core_key", core_key, K1);
    check("ecb_c1_core_din", core_data_in, PT_C1);
    expect_result("ecb_c1", CT_C1);

    // CBC block 1, IV loaded together with the first word
    mode = 1'b1;
    key  = K2;
    send_block(PT1, 4, 0, IV);
    check("cbc1_core_din", core_data_in, IN1);
    expect_result("cbc1", CT1);

    // ECB block between CBC blocks, held under backpressure
    mode      = 1'b0;
    out_ready = 1'b0;
    send_block(PT1, 4, -1, '0);
    check("ecb_mix_core_din", core_data_in, PT1);
    expect_result("ecb_mix", CT_E1);
    w0       = words;
    x0       = xfers;
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data",  out_data,  CT_E1);
      check("bp_core_key",  core_key,  K2);
    end
    check("bp_no_words", words, w0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid_cleared", out_valid, 0);
    check("bp_one_transfer",  xfers, x0 + 1);
    check("bp_still_no_words", words, w0);

    // CBC block 2 with iv_load attempts mid-block and during WAIT
    mode = 1'b1;
    send_block(PT2, 4, 2, BOGUS);
    iv_load = 1'b1;
    iv      = BOGUS;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
    check("cbc2_core_din", core_data_in, IN2);
    expect_result("cbc2", CT2);

    // Reset after three words of a block
    mode = 1'b0;
    key  = K1;
    send_block(PT_C1, 3, -1, '0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send_block(PT_C1, 4, -1, '0);
    expect_result("post_reset_ecb", CT_C1);

    // Chain must have been cleared by reset: CBC without IV equals ECB here
    mode = 1'b1;
    send_block(PT_C1, 4, -1, '0);
    check("post_reset_cbc_core_din", core_data_in, PT_C1);
    expect_result("post_reset_cbc", CT_C1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
